// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: load-use hazard detection, multi-cycle EX sequencing and stall/flush arbitration
module pipe_stall_ctrl #(
    parameter int MC_CYCLES = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_reg1_read_i,
    input  logic             id_reg2_read_i,
    input  logic [4:0]       id_reg1_addr_i,
    input  logic [4:0]       id_reg2_addr_i,
    input  logic             ex_wreg_i,
    input  logic [4:0]       ex_wd_i,
    input  logic             ex_is_load_i,
    input  logic             ex_mc_start_i,
    input  logic             flush_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             mc_busy_o,
    output logic             mc_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [5:0] cnt, cnt_nx;
    logic lu, mc_stall;
    always_comb begin
        lu = ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
             ((id_reg1_read_i && id_reg1_addr_i == ex_wd_i) ||
              (id_reg2_read_i && id_reg2_addr_i == ex_wd_i));
        mc_stall = (state == IDLE && ex_mc_start_i) || state == BUSY;
        state_nx = state;
        cnt_nx = cnt;
        if (flush_i) begin
            state_nx = IDLE;
            cnt_nx = 6'd0;
        end else if (state == IDLE) begin
            state_nx = ex_mc_start_i ? BUSY : IDLE;
            cnt_nx = ex_mc_start_i ? 6'(MC_CYCLES - 1) : cnt;
        end else if (state == BUSY) begin
            state_nx = (cnt == 6'd0) ? DONE : BUSY;
            cnt_nx = (cnt == 6'd0) ? cnt : cnt - 6'd1;
        end else begin
            state_nx = IDLE;
        end
        // outputs are held low for the whole time reset is asserted
        stall_o = (rst || flush_i) ? 6'b000000 : mc_stall ? 6'b001111 : lu ? 6'b000111 : 6'b000000;
        flush_o = !rst && flush_i;
        mc_busy_o = !rst && !flush_i && state == BUSY;
        mc_done_o = !rst && !flush_i && state == DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 6'd0;
            stall_cnt_o <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (stall_o != 6'b000000 && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
endmodule
